truth_table_reader: RTL

Sequential stimulus-and-capture block that characterises one 3-input, 1-output combinational gate circuit (for example, a 0x12 logic function). On `start`, it drives all eight input combinations in order, waits a programmable settle time for each, and samples the circuit output. It assembles the results into the 8-bit truth-table code and compares that code against an expected value. It sits between the test/control logic and a gate-level netlist under characterisation.

---
 rtl/truth_table_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/truth_table_reader.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_reader
//  Description : Characterises a 3-input / 1-output combinational circuit.
//                On start it walks the eight input rows 000..111, holds each
//                row for SETTLE_CYCLES+1 cycles, samples the circuit output on
//                the last cycle of the row and assembles an 8-bit truth-table
//                code (row 000 -> bit 7, row 111 -> bit 0). The finished code
//                is compared against an expected value.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE_CYCLES : extra hold cycles per row before sampling (0..255)
//  Ports
//    clk           : rising-edge clock
//    rst           : synchronous active-high reset
//    start         : request a scan (honoured only when idle)
//    abort         : cancel a scan in progress (discards everything)
//    expected[7:0] : reference code, sampled as the scan completes
//    dut_out       : output of the circuit under characterisation
//    in1/in2/in3   : stimulus row, in1 is the MSB of the row index
//    busy          : high from scan acceptance through the finish cycle
//    done          : one-cycle pulse when a scan completes
//    table_code    : last completed truth-table code
//    match         : table_code == expected, registered with table_code
// ============================================================================
module truth_table_reader #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_code,
    output logic       match
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DRIVE  = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;

    localparam logic [7:0] c_SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [2:0] c_LAST_ROW = 3'd7;

    logic [1:0] r_state;
    logic [2:0] r_row;
    logic [7:0] r_settle;
    logic [7:0] r_work;
    logic [7:0] w_work_sampled;

    // Work register with the current sample merged in. For a 3-bit row,
    // 7 - row is simply the bitwise inverse, so row 0 lands in bit 7.
    // The final row's result goes straight to table_code from here, so the
    // last sample is included without an extra cycle.
    always_comb begin
        w_work_sampled          = r_work;
        w_work_sampled[~r_row]  = dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_row      <= 3'd0;
            r_settle   <= 8'd0;
            r_work     <= 8'd0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            in3        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_code <= 8'd0;
            match      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    done <= 1'b0;
                    // A simultaneous abort cancels the request outright.
                    if (start && !abort) begin
                        r_state         <= c_ST_DRIVE;
                        busy            <= 1'b1;
                        r_row           <= 3'd0;
                        r_settle        <= 8'd0;
                        r_work          <= 8'd0;
                        {in1, in2, in3} <= 3'd0;
                    end
                end

                c_ST_DRIVE: begin
                    if (abort) begin
                        // Abort wins over a sample due this cycle; results
                        // from the previous completed scan are preserved.
                        r_state         <= c_ST_IDLE;
                        busy            <= 1'b0;
                        {in1, in2, in3} <= 3'd0;
                    end else if (r_settle != c_SETTLE) begin
                        r_settle <= r_settle + 8'd1;
                    end else begin
                        r_work <= w_work_sampled;
                        if (r_row != c_LAST_ROW) begin
                            r_row           <= r_row + 3'd1;
                            r_settle        <= 8'd0;
                            {in1, in2, in3} <= r_row + 3'd1;
                        end else begin
                            r_state    <= c_ST_FINISH;
                            done       <= 1'b1;
                            table_code <= w_work_sampled;
                            match      <= (w_work_sampled == expected);
                        end
                    end
                end

                c_ST_FINISH: begin
                    r_state         <= c_ST_IDLE;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    {in1, in2, in3} <= 3'd0;
                end

                default: begin
                    r_state         <= c_ST_IDLE;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    {in1, in2, in3} <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
